ps2_host_tx: RTL

Host-to-device PS/2 transmitter that sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to an attached keyboard over the open-drain PS/2 clock/data pair. It runs alongside the receive/decode path, which owns the bus whenever this block is idle. It executes the full request-to-send sequence, shifts the frame on device-generated clock edges, samples the device ACK and reports completion.

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_sync_edge.sv | 34 +++
 rtl/ps2_host_tx.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, default timing
// constants and the frame parity helper used by both transmit and receive paths.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAIT_IDLE
  } state_t;

  localparam int unsigned DEF_INHIBIT_CYCLES = 5000;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 750000;

  // PS/2 frames carry odd parity: the bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for the raw PS/2 clock/data lines plus falling-edge
// detect on the synchronized clock. Shared with the receive path.
module ps2_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall_c
);

  logic [1:0] clk_ff;
  logic [1:0] data_ff;
  logic       clk_prev;

  // Lines idle high, so reset to 1 to avoid a spurious edge after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_ff   <= 2'b11;
      data_ff  <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_ff   <= {clk_ff[0], ps2_clk_in};
      data_ff  <= {data_ff[0], ps2_data_in};
      clk_prev <= clk_ff[1];
    end
  end

  assign clk_sync   = clk_ff[1];
  assign data_sync  = data_ff[1];
  assign clk_fall_c = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, frame shift on device
// clock falling edges, ACK sampling, timeout abort and completion report.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       ack_ok,
  output logic       err_timeout
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                      : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned EDGE_W  = 4;
  localparam int unsigned SHIFT_W = 9;

  state_t               state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [EDGE_W-1:0]    edge_cnt, edge_cnt_d;
  logic [SHIFT_W-1:0]   shreg, shreg_d;
  logic                 clk_oe_d, data_oe_d, done_d, ack_ok_d, err_timeout_d;
  logic                 clk_sync, data_sync, clk_fall_c;
  logic                 accept_c, inhibit_end_c, timeout_c;

  ps2_sync_edge u_sync (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .clk_sync   (clk_sync),
    .data_sync  (data_sync),
    .clk_fall_c (clk_fall_c)
  );

  assign tx_ready      = (state == IDLE) && !reset;
  assign accept_c      = tx_valid && tx_ready;
  assign inhibit_end_c = (cnt == CNT_W'(INHIBIT_CYCLES - 1));
  assign timeout_c     = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      edge_cnt    <= '0;
      shreg       <= '1;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done        <= 1'b0;
      ack_ok      <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      edge_cnt    <= edge_cnt_d;
      shreg       <= shreg_d;
      ps2_clk_oe  <= clk_oe_d;
      ps2_data_oe <= data_oe_d;
      done        <= done_d;
      ack_ok      <= ack_ok_d;
      err_timeout <= err_timeout_d;
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d       = state;
    cnt_d         = cnt + CNT_W'(1);
    edge_cnt_d    = edge_cnt;
    shreg_d       = shreg;
    clk_oe_d      = ps2_clk_oe;
    data_oe_d     = ps2_data_oe;
    done_d        = 1'b0;
    ack_ok_d      = ack_ok;
    err_timeout_d = err_timeout;

    case (state)
      IDLE: begin
        cnt_d     = '0;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (accept_c) begin
          state_d       = INHIBIT;
          edge_cnt_d    = '0;
          shreg_d       = {odd_parity(tx_data), tx_data};
          clk_oe_d      = 1'b1;
          ack_ok_d      = 1'b0;
          err_timeout_d = 1'b0;
        end
      end
      INHIBIT: begin
        if (inhibit_end_c) begin
          state_d   = REQ;
          cnt_d     = '0;
          data_oe_d = 1'b1;
        end
      end
      REQ: begin
        state_d   = SHIFT;
        cnt_d     = '0;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b1;
      end
      SHIFT: begin
        // Parity sits above D7; ones shifted in behind it form the stop bit.
        if (clk_fall_c) begin
          cnt_d      = '0;
          data_oe_d  = ~shreg[0];
          shreg_d    = {1'b1, shreg[SHIFT_W-1:1]};
          edge_cnt_d = edge_cnt + EDGE_W'(1);
          if (edge_cnt == EDGE_W'(9)) state_d = ACK;
        end else if (timeout_c) begin
          state_d = IDLE;
        end
      end
      ACK: begin
        if (clk_fall_c) begin
          cnt_d    = '0;
          ack_ok_d = ~data_sync;
          state_d  = WAIT_IDLE;
        end else if (timeout_c) begin
          state_d = IDLE;
        end
      end
      WAIT_IDLE: begin
        if (clk_sync && data_sync) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (clk_fall_c) begin
          cnt_d = '0;
        end else if (timeout_c) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort path shared by every bus-watching state.
    if ((state == SHIFT || state == ACK || state == WAIT_IDLE) && state_d == IDLE && !done_d) begin
      clk_oe_d      = 1'b0;
      data_oe_d     = 1'b0;
      done_d        = 1'b1;
      ack_ok_d      = 1'b0;
      err_timeout_d = 1'b1;
    end
  end

endmodule
